// File: rtl/fpuadd_sched.sv
// fpuadd_sched: round-robin scheduler sharing one pipelined fpuadd64 unit with a credit-checked response FIFO.
// Define FPADD_SCHED_STATS_EN to add the stat_issued/stat_stall counters.
module fpuadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT = 2,
  parameter int RDEPTH = 4,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*64-1:0] req_a,
  input  logic [NREQ*64-1:0] req_b,
  input  logic [NREQ*2-1:0]  req_op,
  input  logic [NREQ-1:0]    req_rnd,
  output logic [63:0]        unit_a,
  output logic [63:0]        unit_b,
  output logic               unit_rnd,
  output logic               unit_pookm,
  output logic               unit_pookg,
  input  logic [63:0]        unit_res,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [63:0]        rsp_data,
  output logic [IDW-1:0]     rsp_id,
  output logic               rsp_err,
  output logic               busy
`ifdef FPADD_SCHED_STATS_EN
  ,
  output logic [31:0]        stat_issued,
  output logic [31:0]        stat_stall
`endif
);
  localparam int PW = $clog2(RDEPTH);
  localparam int CW = $clog2(RDEPTH + LAT + 3);
  logic [IDW-1:0] rr, win;
  logic found, can_issue, accept, push, pop, bypass;
  logic [1:0] op;
  logic [CW-1:0] count, inflight, cnt_n;
  logic [PW-1:0] rd_ptr, wr_ptr, rd_n;
  logic [LAT:0] pv, perr;
  logic [LAT:0][IDW-1:0] pid;
  logic [63:0] push_d;
  logic [63:0] mem_d [RDEPTH];
  logic [IDW-1:0] mem_id [RDEPTH];
  logic mem_err [RDEPTH];
  // stage 0 of pv/pid/perr is the issue register; stage LAT lines up with unit_res
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= LAT; i++) inflight = inflight + CW'(pv[i]);
  end
  assign can_issue = count + inflight + CW'(1) <= CW'(RDEPTH);
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 1; k <= NREQ; k++)
      if (!found && req_valid[IDW'((int'(rr) + k) % NREQ)]) begin
        found = 1'b1;
        win = IDW'((int'(rr) + k) % NREQ);
      end
  end
  assign accept = can_issue && found;
  assign req_ready = (accept && rst) ? NREQ'(1) << win : '0;
  assign op = req_op[2*win +: 2];
  assign push = pv[LAT];
  assign pop = rsp_valid && rsp_ready;
  assign push_d = perr[LAT] ? '0 : unit_res;
  assign cnt_n = count + CW'(push) - CW'(pop);
  assign rd_n = rd_ptr + PW'(pop);
  assign bypass = push && wr_ptr == rd_n;
  assign busy = inflight != '0 || count != '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      unit_a <= '0;
      unit_b <= '0;
      unit_rnd <= 1'b0;
      unit_pookm <= 1'b0;
      unit_pookg <= 1'b0;
      rr <= IDW'(NREQ - 1);
      pv <= '0;
      pid <= '0;
      perr <= '0;
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_id <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        unit_a <= req_a[64*win +: 64];
        unit_b <= req_b[64*win +: 64];
        unit_rnd <= req_rnd[win];
        rr <= win;
      end
      unit_pookm <= accept && op == 2'b01;
      unit_pookg <= accept && op == 2'b10;
      pv <= {pv[LAT-1:0], accept};
      pid <= {pid[LAT-1:0], win};
      perr <= {perr[LAT-1:0], op == 2'b11};
      count <= cnt_n;
      rd_ptr <= rd_n;
      wr_ptr <= wr_ptr + PW'(push);
      rsp_valid <= cnt_n != '0;
      rsp_data <= cnt_n == '0 ? '0 : bypass ? push_d : mem_d[rd_n];
      rsp_id <= cnt_n == '0 ? '0 : bypass ? pid[LAT] : mem_id[rd_n];
      rsp_err <= cnt_n != '0 && (bypass ? perr[LAT] : mem_err[rd_n]);
    end
  always_ff @(posedge clk)
    if (push) begin
      mem_d[wr_ptr] <= push_d;
      mem_id[wr_ptr] <= pid[LAT];
      mem_err[wr_ptr] <= perr[LAT];
    end
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(push && count == CW'(RDEPTH)));
`ifdef FPADD_SCHED_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      stat_issued <= '0;
      stat_stall <= '0;
    end else begin
      stat_issued <= stat_issued + 32'(accept);
      stat_stall <= stat_stall + 32'(|req_valid && !accept);
    end
`endif
endmodule

// File: tb/tb_fpuadd_sched.sv
// tb_fpuadd_sched: directed bench for fpuadd_sched driving a behavioural two-stage adder as the shared unit.
module tb_fpuadd_sched;
  localparam int NREQ = 4, LAT = 2, RDEPTH = 4, IDW = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic [NREQ-1:0] req_valid, req_ready, req_rnd;
  logic [NREQ*64-1:0] req_a, req_b;
  logic [NREQ*2-1:0] req_op;
  logic [63:0] unit_a, unit_b, unit_res, rsp_data, u1, u2;
  logic unit_rnd, unit_pookm, unit_pookg, rsp_valid, rsp_ready, rsp_err, busy;
  logic [IDW-1:0] rsp_id;
`ifdef FPADD_SCHED_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif
  typedef struct packed { logic [IDW-1:0] id; logic err; logic [63:0] d; } rsp_t;
  rsp_t exp_q[$];
  rsp_t mon_e;
  int gnt_q[$];
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  fpuadd_sched #(.NREQ(NREQ), .LAT(LAT), .RDEPTH(RDEPTH), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_rnd(req_rnd),
    .unit_a(unit_a), .unit_b(unit_b), .unit_rnd(unit_rnd), .unit_pookm(unit_pookm),
    .unit_pookg(unit_pookg), .unit_res(unit_res), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err), .busy(busy)
`ifdef FPADD_SCHED_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );
  // stand-in unit: two register stages, result = a + b + {pookg, pookm, rnd}
  always @(posedge clk) begin
    u1 <= unit_a + unit_b + {61'd0, unit_pookg, unit_pookm, unit_rnd};
    u2 <= u1;
  end
  assign unit_res = u2;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  // scoreboard: pop on handshake, then record new accepts in grant order
  always @(negedge clk) if (rst) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) check("rsp_extra", 64'd1, 64'd0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", rsp_data, mon_e.d);
        check("rsp_id", 64'(rsp_id), 64'(mon_e.id));
        check("rsp_err", 64'(rsp_err), 64'(mon_e.err));
      end
    end
    for (int i = 0; i < NREQ; i++)
      if (req_valid[i] && req_ready[i]) begin
        mon_e.id = IDW'(i);
        mon_e.err = req_op[2*i +: 2] == 2'b11;
        mon_e.d = mon_e.err ? 64'd0 : req_a[64*i +: 64] + req_b[64*i +: 64]
                  + {61'd0, req_op[2*i +: 2] == 2'b10, req_op[2*i +: 2] == 2'b01, req_rnd[i]};
        exp_q.push_back(mon_e);
        gnt_q.push_back(i);
      end
  end
  always @(negedge rst) exp_q.delete();
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] o, input logic r);
    req_a[64*id +: 64] = a;
    req_b[64*id +: 64] = b;
    req_op[2*id +: 2] = o;
    req_rnd[id] = r;
  endtask
  task automatic chk_reset_outs(input string tag);
    check({tag, "_ctl"}, 64'({req_ready, unit_rnd, unit_pookm, unit_pookg, rsp_valid, rsp_err, rsp_id, busy}), 64'd0);
    check({tag, "_ua"}, unit_a, 64'd0);
    check({tag, "_ub"}, unit_b, 64'd0);
    check({tag, "_data"}, rsp_data, 64'd0);
  endtask
  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && busy; k++) tick(1);
    check("drain_busy", 64'(busy), 64'd0);
    check("drain_q", 64'(exp_q.size()), 64'd0);
  endtask
  // lone op on an idle scheduler: accept edge n, response visible after n+3, consumed at n+4
  task automatic issue_one(input int id, input logic [63:0] a, input logic [63:0] b, input logic [1:0] o,
                           input logic r, input logic [63:0] exp_d);
    set_req(id, a, b, o, r);
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    #1 check("issue_rdy", 64'(req_ready), 64'd1 << id);
    @(posedge clk);
    #1 req_valid = '0;
    check("pookm", 64'(unit_pookm), 64'(o == 2'b01));
    check("pookg", 64'(unit_pookg), 64'(o == 2'b10));
    check("unit_a", unit_a, a);
    tick(2);
    check("rsp_early", 64'(rsp_valid), 64'd0);
    tick(1);
    check("rsp_lat", 64'(rsp_valid), 64'd1);
    check("rsp_val", rsp_data, exp_d);
    check("rsp_errf", 64'(rsp_err), 64'(o == 2'b11));
    tick(1);
    check("idle", 64'(busy), 64'd0);
  endtask
  initial begin
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    req_rnd = '0;
    rsp_ready = 1'b0;
    tick(3);
    chk_reset_outs("rst_init");
    rst = 1'b1;
    tick(1);
`ifdef FPADD_SCHED_STATS_EN
    set_req(0, 64'h10, 64'h20, 2'b00, 1'b0);
    req_valid = 4'b0001;
    tick(9);
    req_valid = '0;
    drain();
    for (int k = 0; k < 6; k++) issue_one(0, 64'h10, 64'h20, 2'b00, 1'b0, 64'h30);
    check("stat_issued", 64'(stat_issued), 64'd10);
    check("stat_stall", 64'(stat_stall), 64'd5);
`endif
    issue_one(0, 64'h4000000000000000, 64'h4000000000000000, 2'b00, 1'b0, 64'h8000000000000000);
    for (int i = 0; i < NREQ; i++) set_req(i, 64'h100 * (i + 1), 64'(i), 2'b00, 1'b0);
    gnt_q.delete();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 80 && gnt_q.size() < 8; k++) tick(1);
    req_valid = '0;
    for (int k = 0; k < 8; k++) check("rr_gnt", 64'(k < gnt_q.size() ? gnt_q[k] : 99), 64'((k + 1) % NREQ));
    drain();
    gnt_q.delete();
    rsp_ready = 1'b0;
    set_req(0, 64'h1000, 64'h1, 2'b00, 1'b0);
    req_valid = 4'b0001;
    tick(10);
    check("bp_accepts", 64'(gnt_q.size()), 64'd4);
    check("bp_rdy_full", 64'(req_ready), 64'd0);
    check("bp_head", rsp_data, 64'h1001);
    rsp_ready = 1'b1;
    tick(1);
    rsp_ready = 1'b0;
    check("bp_rdy_pop", 64'(req_ready), 64'd1);
    tick(1);
    check("bp_accepts2", 64'(gnt_q.size()), 64'd5);
    check("bp_rdy_again", 64'(req_ready), 64'd0);
    drain();
    issue_one(1, 64'h3ff0000000000000, 64'h1, 2'b01, 1'b1, 64'h3ff0000000000004);
    issue_one(2, 64'h10, 64'h20, 2'b10, 1'b0, 64'h34);
    issue_one(3, 64'hdead, 64'hbeef, 2'b11, 1'b1, 64'h0);
    rsp_ready = 1'b0;
    set_req(0, 64'h777, 64'h1, 2'b00, 1'b0);
    req_valid = 4'b0001;
    tick(5);
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst = 1'b0;
    #1 chk_reset_outs("rst_async");
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      check("post_rst_quiet", 64'({rsp_valid, busy}), 64'd0);
    end
    req_valid = '1;
    #1 check("rr_after_rst", 64'(req_ready), 64'd1);
    req_valid = '0;
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
